// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - raster-order frame readback, each 24-bit pixel sent as 3 bytes (LSB first).
// Define FRAME_SCANOUT_PREFETCH_EN to overlap the next pixel's read with the current pixel's bytes.
module frame_scanout #(
  parameter int H_PIXELS = 110,
  parameter int V_LINES  = 110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        mem_rd_en,
  output logic [9:0]  mem_line,
  output logic [9:0]  mem_px,
  input  logic [23:0] mem_rd_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [9:0]  px_idx,
  output logic [9:0]  line_idx,
  output logic        frame_done
);

  localparam logic [9:0] H_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(V_LINES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND0, SEND1, SEND2, DONE} state_t;

  state_t      state;
  logic [23:0] pix;
  logic [9:0]  px_cnt;
  logic [9:0]  line_cnt;
  logic        rd_q;
  logic        hs;
  logic        last_px;
  logic [19:0] nxt;

  function automatic logic [19:0] next_coord(input logic [9:0] l, input logic [9:0] p);
    if (p == H_LAST) return {l + 10'd1, 10'd0};
    return {l, p + 10'd1};
  endfunction

  assign hs       = byte_valid & byte_ready;
  assign last_px  = (px_cnt == H_LAST) && (line_cnt == V_LAST);
  assign nxt      = next_coord(line_cnt, px_cnt);
  assign px_idx   = px_cnt;
  assign line_idx = line_cnt;

`ifdef FRAME_SCANOUT_PREFETCH_EN
  logic [23:0] pix2;
  logic        pf_cap;
  logic        pf_rd;
  // The next pixel's read rides on the SEND0 handshake; mem_line/mem_px already point at it.
  assign pf_rd     = (state == SEND0) && hs && !last_px;
  assign mem_rd_en = rd_q | pf_rd;
`else
  assign mem_rd_en = rd_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rd_q       <= 1'b0;
      mem_line   <= '0;
      mem_px     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      pix        <= '0;
      px_cnt     <= '0;
      line_cnt   <= '0;
`ifdef FRAME_SCANOUT_PREFETCH_EN
      pix2       <= '0;
      pf_cap     <= 1'b0;
`endif
    end else begin
      rd_q       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_SCANOUT_PREFETCH_EN
      pf_cap <= pf_rd;
      if (pf_cap) pix2 <= mem_rd_data;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            px_cnt   <= '0;
            line_cnt <= '0;
            mem_line <= '0;
            mem_px   <= '0;
            rd_q     <= 1'b1;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          pix        <= mem_rd_data;
          byte_out   <= mem_rd_data[7:0];
          byte_valid <= 1'b1;
`ifdef FRAME_SCANOUT_PREFETCH_EN
          mem_line   <= nxt[19:10];
          mem_px     <= nxt[9:0];
`endif
          state      <= SEND0;
        end
        SEND0: begin
          if (hs) begin
            byte_out <= pix[15:8];
            state    <= SEND1;
          end
        end
        SEND1: begin
          if (hs) begin
            byte_out <= pix[23:16];
            state    <= SEND2;
          end
        end
        SEND2: begin
          if (hs) begin
            if (last_px) begin
              byte_valid <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              px_cnt   <= nxt[9:0];
              line_cnt <= nxt[19:10];
`ifdef FRAME_SCANOUT_PREFETCH_EN
              pix      <= pix2;
              byte_out <= pix2[7:0];
              {mem_line, mem_px} <= next_coord(nxt[19:10], nxt[9:0]);
              state    <= SEND0;
`else
              byte_valid <= 1'b0;
              mem_line   <= nxt[19:10];
              mem_px     <= nxt[9:0];
              rd_q       <= 1'b1;
              state      <= FETCH;
`endif
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - directed bench for frame_scanout with a pixel-pattern memory model.
module tb_frame_scanout;

  localparam int H = 110;
  localparam int V = 110;
`ifdef FRAME_SCANOUT_PREFETCH_EN
  localparam int EXP_CYC = 1 + 2 + H * V * 3 + 1;
`else
  localparam int EXP_CYC = 1 + H * V * 5 + 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        mem_rd_en;
  logic [9:0]  mem_line;
  logic [9:0]  mem_px;
  logic [23:0] mem_rd_data = '0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [9:0]  px_idx;
  logic [9:0]  line_idx;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  frame_scanout #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_line(mem_line), .mem_px(mem_px), .mem_rd_data(mem_rd_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .px_idx(px_idx), .line_idx(line_idx), .frame_done(frame_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: pixel (l,p) = {l, p, A5}, one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {mem_line[7:0], mem_px[7:0], 8'hA5};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit       mon_en = 1'b0;
  bit       stall_q = 1'b0;
  int       exp_l = 0, exp_p = 0, exp_b = 0, n_bytes = 0, n_rd = 0;
  logic [7:0] hold_b, eb;
  logic [9:0] hold_p;

  always @(negedge clk) begin
    if (mon_en && mem_rd_en) n_rd++;
    if (mon_en && byte_valid) begin
      if (stall_q) begin
        check("hold_byte", byte_out, hold_b);
        check("hold_px", px_idx, hold_p);
      end
      if (byte_ready) begin
        case (exp_b)
          0:       eb = 8'hA5;
          1:       eb = 8'(exp_p);
          default: eb = 8'(exp_l);
        endcase
        check("byte", byte_out, eb);
        check("px_idx", px_idx, 64'(exp_p));
        check("line_idx", line_idx, 64'(exp_l));
        n_bytes++;
        stall_q = 1'b0;
        if (exp_b == 2) begin
          exp_b = 0;
          if (exp_p == H - 1) begin exp_p = 0; exp_l++; end
          else exp_p++;
        end else exp_b++;
      end else begin
        stall_q = 1'b1;
        hold_b  = byte_out;
        hold_p  = px_idx;
      end
    end else stall_q = 1'b0;
  end

  task automatic clear_exp();
    exp_l = 0; exp_p = 0; exp_b = 0; n_bytes = 0; n_rd = 0;
  endtask

  int  t0, nd;
  bit  done, found;

  initial begin
    // Reset held with random inputs: every output stays 0.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start      = 1'($urandom_range(0, 1));
      byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_outs", {busy, mem_rd_en, mem_line, mem_px, byte_out, byte_valid, px_idx, line_idx, frame_done}, 0);
    end
    @(posedge clk); #1;
    start = 1'b0; byte_ready = 1'b1; reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
    end

    // Full frame, byte_ready held high, stray start at cycle 50.
    clear_exp(); mon_en = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; t0 = cyc; start = 1'b0;
    @(negedge clk);
    check("k1_rd_en", mem_rd_en, 1);
    check("k1_busy", busy, 1);
    check("k1_valid", byte_valid, 0);
    @(negedge clk);
    check("k2_valid", byte_valid, 0);
    @(negedge clk);
    check("k3_valid", byte_valid, 1);
    done = 1'b0;
    while (!done && (cyc - t0) < 70000) begin
      @(posedge clk); #1; start = ((cyc - t0) == 50);
      @(negedge clk); if (frame_done) done = 1'b1;
    end
    check("done_seen", done, 1);
    check("done_cycles", 64'(cyc - t0 + 2), 64'(EXP_CYC));
    check("done_busy", busy, 1);
    check("bytes_total", 64'(n_bytes), 64'(3 * H * V));
    check("end_line", 64'(exp_l), 64'(V));
    @(negedge clk);
    check("post_done", {busy, frame_done}, 0);
    repeat (5) @(negedge clk);
    check("reads_total", 64'(n_rd), 64'(H * V));

    // New scan with random byte_ready; reset during SEND1 of pixel (3,7).
    mon_en = 1'b0; clear_exp(); mon_en = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; t0 = cyc; start = 1'b0;
    found = 1'b0;
    while (!found && (cyc - t0) < 20000) begin
      @(posedge clk); #1; byte_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (byte_valid && line_idx == 10'd3 && px_idx == 10'd7 && byte_out == 8'h07) found = 1'b1;
    end
    check("send1_3_7_seen", found, 1);
    check("bytes_before_rst", 64'(n_bytes), 64'(3 * (3 * H + 7) + 1));
    #2; mon_en = 1'b0; reset = 1'b0;
    #1;
    check("async_valid", byte_valid, 0);
    check("async_state", {busy, mem_rd_en, px_idx, line_idx}, 0);
    nd = 0;
    repeat (3) begin @(negedge clk); if (frame_done) nd++; end
    @(posedge clk); #1; reset = 1'b1; byte_ready = 1'b1;
    repeat (10) begin @(negedge clk); if (frame_done) nd++; end
    check("no_done_after_rst", 64'(nd), 0);
    check("rst_busy", busy, 0);

    // Restart after reset scans from (0,0).
    clear_exp(); mon_en = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; t0 = cyc; start = 1'b0;
    while (n_bytes < 3 * (H + 2) && (cyc - t0) < 2000) @(negedge clk);
    check("restart_bytes", 64'(n_bytes >= 3 * (H + 2)), 1);
    check("restart_pos", {32'(exp_l), 32'(exp_p)}, {32'd1, 32'd2});
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
